// File: rtl/key_debouncer.sv
// Per-bit switch debouncer: a 2-flop synchronizer feeds a saturating stability counter.
// An accepted level change produces a one-cycle rise/fall strobe and sets a sticky write-1-to-clear flag.
module key_debouncer #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_flags,
  input  logic [WIDTH-1:0] edge_clr
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_flags;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_toggle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // A bit toggles once the synchronized level has disagreed for DB_CYCLES consecutive edges.
  always_comb begin
    w_diff   = r_sync2 ^ r_db;
    w_hit    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_hit[i] = (r_cnt[i] == CNT_MAX);
    end
    w_toggle = w_diff & w_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_hit[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set wins over clear so a change coinciding with edge_clr is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db    <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_flags <= '0;
    end else begin
      r_db    <= r_db ^ w_toggle;
      r_rise  <= w_toggle & ~r_db;
      r_fall  <= w_toggle & r_db;
      r_flags <= w_toggle | (r_flags & ~edge_clr);
    end
  end

  assign db_out     = r_db;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign edge_flags = r_flags;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer (WIDTH=8, DB_CYCLES=4): directed scenarios plus random stimulus,
// with a window-based reference model feeding an expected-output queue checked every cycle.
module tb_key_debouncer;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] edge_flags;
  logic [W-1:0] edge_clr;

  int errors = 0;
  int checks = 0;
  int rise2_cnt = 0;

  logic [4*W-1:0] exp_q[$];

  key_debouncer #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_flags (edge_flags),
    .edge_clr   (edge_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronized level is the raw input sampled two edges earlier;
  // a bit flips when each of the last DB synchronized samples differs from the accepted level.
  logic [W-1:0] m_db;
  logic [W-1:0] m_flags;
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s_hist[$];

  always @(posedge clk) begin
    logic [W-1:0] s;
    logic [W-1:0] tog;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         all_diff;
    if (reset) begin
      m_db     = '0;
      m_flags  = '0;
      raw_hist = '{8'h00, 8'h00};
      s_hist.delete();
      exp_q.push_back('0);
    end else begin
      s = raw_hist.pop_front();
      raw_hist.push_back(raw_in);
      s_hist.push_back(s);
      if (s_hist.size() > DB) void'(s_hist.pop_front());
      tog = '0;
      if (s_hist.size() == DB) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++) begin
            if (s_hist[j][i] == m_db[i]) all_diff = 1'b0;
          end
          tog[i] = all_diff;
        end
      end
      rise    = tog & ~m_db;
      fall    = tog & m_db;
      m_db    = m_db ^ tog;
      m_flags = tog | (m_flags & ~edge_clr);
      exp_q.push_back({m_db, rise, fall, m_flags});
    end
  end

  // Monitor: registered outputs are compared against the scoreboard every cycle
  always @(posedge clk) begin
    logic [4*W-1:0] e;
    #2;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_db_out",     32'(db_out),     32'(e[4*W-1:3*W]));
      check("sb_rise_pulse", 32'(rise_pulse), 32'(e[3*W-1:2*W]));
      check("sb_fall_pulse", 32'(fall_pulse), 32'(e[2*W-1:W]));
      check("sb_edge_flags", 32'(edge_flags), 32'(e[W-1:0]));
    end
  end

  always @(negedge clk) begin
    if (rise_pulse[2]) rise2_cnt++;
  end

  // Driver tasks: inputs change only on the falling edge
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [W-1:0] raw_during);
    @(negedge clk);
    reset    = 1'b1;
    raw_in   = raw_during;
    edge_clr = '0;
    #1;
    check("reset_immediate", {db_out, rise_pulse, fall_pulse, edge_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    raw_in   = '0;
    edge_clr = '0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(2);
    check("reset_state", {db_out, rise_pulse, fall_pulse, edge_flags}, 32'd0);

    // Clean press
    @(negedge clk); raw_in = 8'h01;
    wait_neg(5);
    check("press_db_early", 32'(db_out), 32'h00);
    wait_neg(1);
    check("press_db", 32'(db_out), 32'h01);
    check("press_rise", 32'(rise_pulse), 32'h01);
    wait_neg(1);
    check("press_rise_once", 32'(rise_pulse), 32'h00);
    check("press_flag", 32'(edge_flags), 32'h01);

    // Glitch rejection, then a pulse just long enough
    do_reset(8'h00);
    @(negedge clk); raw_in = 8'h01;
    wait_neg(3); raw_in = 8'h00;
    wait_neg(8);
    check("glitch_db", 32'(db_out), 32'h00);
    check("glitch_flags", 32'(edge_flags), 32'h00);
    raw_in = 8'h01;
    wait_neg(4); raw_in = 8'h00;
    wait_neg(2);
    check("pulse4_db_high", 32'(db_out), 32'h01);
    wait_neg(8);
    check("pulse4_db_low", 32'(db_out), 32'h00);
    check("pulse4_flags", 32'(edge_flags), 32'h01);

    // Bounce on bit 2
    do_reset(8'h00);
    rise2_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      raw_in = 8'h04; wait_neg(2);
      raw_in = 8'h00; wait_neg(2);
    end
    raw_in = 8'h04;
    wait_neg(5);
    check("bounce_db_early", 32'(db_out), 32'h00);
    wait_neg(1);
    check("bounce_db", 32'(db_out), 32'h04);
    wait_neg(3);
    check("bounce_single_rise", 32'(rise2_cnt), 32'd1);

    // Multi-bit press and release
    do_reset(8'h00);
    @(negedge clk); raw_in = 8'hA5;
    wait_neg(6);
    check("multi_db", 32'(db_out), 32'hA5);
    check("multi_rise", 32'(rise_pulse), 32'hA5);
    raw_in = 8'h00;
    wait_neg(6);
    check("multi_fall", 32'(fall_pulse), 32'hA5);
    check("multi_release_db", 32'(db_out), 32'h00);
    raw_in = 8'hA5;
    wait_neg(8);

    // Clear priority
    do_reset(8'h00);
    @(negedge clk); raw_in = 8'h01;
    wait_neg(5); edge_clr = 8'h01;
    wait_neg(1);
    check("clr_prio_flag", 32'(edge_flags), 32'h01);
    check("clr_prio_db", 32'(db_out), 32'h01);
    wait_neg(1);
    check("clr_flag", 32'(edge_flags), 32'h00);
    edge_clr = 8'h00;

    // Reset mid-count with raw held high through release
    do_reset(8'h00);
    @(negedge clk); raw_in = 8'hFF;
    wait_neg(3);
    reset = 1'b1;
    #1;
    check("midcount_reset", {db_out, rise_pulse, fall_pulse, edge_flags}, 32'd0);
    wait_neg(1);
    reset = 1'b0;
    wait_neg(5);
    check("midcount_db_early", 32'(db_out), 32'h00);
    wait_neg(1);
    check("midcount_db", 32'(db_out), 32'hFF);
    check("midcount_rise", 32'(rise_pulse), 32'hFF);

    // Random stimulus against the model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) raw_in = raw_in ^ W'($urandom & $urandom & $urandom);
      edge_clr = ($urandom_range(0, 4) == 0) ? W'($urandom) : '0;
      reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset    = 1'b0;
    edge_clr = '0;
    wait_neg(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input channels; sized to match the 8-bit input port of the downstream PIO.
REQ-002 SHALL have parameter DB_CYCLES, default 50000: consecutive stable clock cycles required to accept a new level; legal range 2..2^20.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port raw_in  input  WIDTH: asynchronous switch/button inputs, possibly bouncing.
REQ-006 SHALL have port db_out  output  WIDTH: registered debounced levels, driving the downstream PIO in_port.
REQ-007 SHALL have port rise_pulse  output  WIDTH: one-cycle strobe per bit on an accepted 0->1 change.
REQ-008 SHALL have port fall_pulse  output  WIDTH: one-cycle strobe per bit on an accepted 1->0 change.
REQ-009 SHALL have port edge_flags  output  WIDTH: sticky per-bit flag, set on any accepted change.
REQ-010 SHALL have port edge_clr  input  WIDTH: per-bit write-1-to-clear for edge_flags, sampled each cycle.

Function
REQ-011 SHALL pass each raw_in bit through a 2-flop synchronizer (sync1, sync2); no logic between the flops.
REQ-012 SHALL keep one counter per bit, width ceil(log2(DB_CYCLES)), with no carry or sharing between bits.
REQ-013 SHALL, on each edge where sync2[i] == db_out[i], clear counter[i] to 0.
REQ-014 SHALL, on each edge where sync2[i] != db_out[i] and counter[i] < DB_CYCLES-1, increment counter[i] by 1.
REQ-015 SHALL, on each edge where sync2[i] != db_out[i] and counter[i] == DB_CYCLES-1, invert db_out[i] and clear counter[i]; the counter SHALL never wrap or exceed DB_CYCLES-1.
REQ-016 SHALL give latency: a raw_in change held stable from before edge 0 appears on db_out after edge DB_CYCLES+1, i.e. the (DB_CYCLES+2)th rising edge.
REQ-017 SHALL reject any raw_in level held for fewer than DB_CYCLES cycles at sync2: no db_out change, no pulse, no flag.
REQ-018 SHALL restart the count from 0 when a bounce returns sync2 to the db_out level; partial counts SHALL NOT accumulate across bounces.
REQ-019 SHALL assert rise_pulse[i] or fall_pulse[i] for exactly one cycle, registered, in the same cycle db_out[i] shows the new level.
REQ-020 SHALL set edge_flags[i] on the edge db_out[i] changes; it holds until an edge with edge_clr[i]=1 and no concurrent change.
REQ-021 SHALL give set priority: when a change and edge_clr[i]=1 occur on the same edge, edge_flags[i] ends at 1.
REQ-022 SHALL let edge_clr[i]=1 with edge_flags[i]=0 have no effect; edge_clr SHALL NOT affect counters, db_out or pulses.
REQ-023 SHALL process all bits independently and simultaneously; changes on several bits in one cycle SHALL each produce their own pulse and flag.

Reset
REQ-024 SHALL, while reset=1, force sync1, sync2, counters, db_out, rise_pulse, fall_pulse and edge_flags to 0 immediately, without waiting for clk.
REQ-025 SHALL abandon any count in progress when reset asserts mid-operation; after release, debouncing restarts from db_out=0.
REQ-026 SHALL treat raw_in=1 held through reset release as a normal 0->1 change: db_out rises after DB_CYCLES+2 edges, with rise_pulse and the flag set.

Verification (DB_CYCLES=4, WIDTH=8)
REQ-027 SHALL cover clean press: raw_in 0x00->0x01, held -> db_out=0x01 at edge 6; rise_pulse=0x01 for one cycle; edge_flags=0x01.
REQ-028 SHALL cover glitch rejection: raw_in[0] high for 3 cycles then low -> db_out, pulses and edge_flags stay 0x00; a 4-cycle pulse -> db_out[0] toggles.
REQ-029 SHALL cover bounce: raw_in[2] 1,0,1,0 each 2 cycles, then 1 held -> db_out=0x04 exactly 6 edges after the final 0->1; a single rise_pulse.
REQ-030 SHALL cover multi-bit and release: raw_in 0x00->0xA5 -> db_out=0xA5 and rise_pulse=0xA5 in one cycle; then 0xA5->0x00 -> fall_pulse=0xA5.
REQ-031 SHALL cover clear priority: edge_clr=0x01 on the edge db_out[0] changes -> edge_flags[0]=1; edge_clr=0x01 one cycle later -> edge_flags[0]=0.
REQ-032 SHALL cover reset mid-count: raw_in=0xFF, reset pulsed 1 cycle after 3 edges -> all outputs 0x00 at once; db_out=0xFF 6 edges after release.
